accelerator_usage_vector: RTL and testbench

- Computes the DNC memory usage vector u(t)[j] = (u(t-1)[j] + w(t-1)[j] - u(t-1)[j]·w(t-1)[j])·psi(t)[j] for j in 0..N-1.
- Sits directly upstream of the allocation weighting stage; its U_OUT stream feeds that stage's U_IN/U_IN_ENABLE.
- Unsigned fixed-point, one element at a time, multi-cycle sequencing per element.

---
 rtl/accelerator_dnc_pkg.sv | 28 ++
 rtl/accelerator_usage_vector_if.sv | 31 +++
 rtl/accelerator_fixed_multiplier.sv | 22 ++
 rtl/accelerator_usage_vector.sv | 153 +++++++++++++++
 tb/tb_accelerator_usage_vector.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/accelerator_dnc_pkg.sv
// Shared DNC accelerator definitions: FSM state encoding, data constants,
// operand-flag values and a fixed-point helper.
package accelerator_dnc_pkg;

    typedef enum logic [2:0] {
        STARTER_STATE,
        INPUT_STATE,
        MULTIPLY_STATE,
        ADD_STATE,
        SCALE_STATE,
        OUTPUT_STATE,
        END_STATE
    } state_t;

    // Data constants at the default 64-bit word / 32 fractional bits.
    localparam logic [63:0] ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;

    // Operand-register occupancy flags.
    localparam logic FULL  = 1'b1;
    localparam logic EMPTY = 1'b0;

    // Fixed-point 1.0 for an arbitrary fraction width.
    function automatic logic [127:0] fixed_one(input int unsigned frac);
        return 128'd1 << frac;
    endfunction

endpackage

// File: rtl/accelerator_usage_vector_if.sv
// Element-stream bus of the usage-vector stage: pass control, the three
// operand streams u/w/psi and the resulting usage stream.
interface accelerator_usage_vector_if #(
    parameter int DATA_SIZE = 64
);
    logic                 START;
    logic                 READY;
    logic                 U_IN_ENABLE;
    logic                 W_IN_ENABLE;
    logic                 PSI_IN_ENABLE;
    logic                 U_OUT_ENABLE;
    logic [DATA_SIZE-1:0] SIZE_N_IN;
    logic [DATA_SIZE-1:0] U_IN;
    logic [DATA_SIZE-1:0] W_IN;
    logic [DATA_SIZE-1:0] PSI_IN;
    logic [DATA_SIZE-1:0] U_OUT;

    // Upstream producer side.
    modport master (
        output START, U_IN_ENABLE, W_IN_ENABLE, PSI_IN_ENABLE,
        output SIZE_N_IN, U_IN, W_IN, PSI_IN,
        input  READY, U_OUT_ENABLE, U_OUT
    );

    // Usage-vector stage side.
    modport slave (
        input  START, U_IN_ENABLE, W_IN_ENABLE, PSI_IN_ENABLE,
        input  SIZE_N_IN, U_IN, W_IN, PSI_IN,
        output READY, U_OUT_ENABLE, U_OUT
    );
endinterface

// File: rtl/accelerator_fixed_multiplier.sv
// Combinational unsigned fixed-point multiply: y = (a*b) >> FRACTION,
// keeping the low OUT_W bits of the shifted full-width product.
module accelerator_fixed_multiplier #(
    parameter int A_W      = 64,
    parameter int B_W      = 64,
    parameter int FRACTION = 32,
    parameter int OUT_W    = A_W + B_W - FRACTION
) (
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic [OUT_W-1:0] y
);
    logic [A_W+B_W-1:0] prod;
    logic [A_W+B_W-1:0] shifted;
    logic               shifted_unused;

    assign prod           = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
    assign shifted        = prod >> FRACTION;
    assign y              = shifted[OUT_W-1:0];
    // Bits above OUT_W are intentionally discarded by the caller's choice.
    assign shifted_unused = ^shifted;
endmodule

// File: rtl/accelerator_usage_vector.sv
// DNC usage vector: u(t)[j] = (u + w - u*w) * psi, one element per pass
// through MULTIPLY -> ADD -> SCALE -> OUTPUT.
// Optional macro ACCELERATOR_USAGE_VECTOR_SATURATE_EN clamps s at 0 and
// the result at ONE; without it, s wraps at DATA_SIZE+1 bits and the result
// is truncated to DATA_SIZE bits.
module accelerator_usage_vector
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int FRACTION     = 32
) (
    input logic                      CLK,
    input logic                      RST,
    accelerator_usage_vector_if.slave bus
);
    localparam int PW_FULL = 2*DATA_SIZE - FRACTION;
    localparam int RW_FULL = 2*DATA_SIZE + 1 - FRACTION;
`ifdef ACCELERATOR_USAGE_VECTOR_SATURATE_EN
    // Clamping needs the whole product to compare against.
    localparam int PQ_W = PW_FULL;
    localparam int RQ_W = RW_FULL;
`else
    // Wrapping arithmetic only ever sees the low bits.
    localparam int PQ_W = DATA_SIZE + 1;
    localparam int RQ_W = DATA_SIZE;
`endif

    state_t                  state_q, state_d;
    logic [CONTROL_SIZE-1:0] index_q;
    logic [DATA_SIZE-1:0]    size_q, u_q, w_q, psi_q, u_out_q, r_out;
    logic                    u_full_q, w_full_q, psi_full_q;
    logic [PQ_W-1:0]         p_q, p_d;
    logic [DATA_SIZE:0]      s_q, s_d, sum;
    logic [RQ_W-1:0]         r_d;
    logic                    u_out_en_q, ready_q, ready_d, last_elem;

    accelerator_fixed_multiplier #(
        .A_W(DATA_SIZE), .B_W(DATA_SIZE), .FRACTION(FRACTION), .OUT_W(PQ_W)
    ) u_mul_uw (.a(u_q), .b(w_q), .y(p_d));

    accelerator_fixed_multiplier #(
        .A_W(DATA_SIZE+1), .B_W(DATA_SIZE), .FRACTION(FRACTION), .OUT_W(RQ_W)
    ) u_mul_scale (.a(s_q), .b(psi_q), .y(r_d));

    assign sum       = {1'b0, u_q} + {1'b0, w_q};
    assign last_elem = (index_q == CONTROL_SIZE'(size_q - DATA_SIZE'(1)));

`ifdef ACCELERATOR_USAGE_VECTOR_SATURATE_EN
    localparam logic [RQ_W-1:0] ONE_R = RQ_W'(fixed_one(FRACTION));
    // When sum >= p, p fits in DATA_SIZE+1 bits so the narrow subtract is exact.
    assign s_d   = (PQ_W'(sum) < p_q) ? '0 : (sum - p_q[DATA_SIZE:0]);
    assign r_out = (r_d > ONE_R) ? ONE_R[DATA_SIZE-1:0] : r_d[DATA_SIZE-1:0];
`else
    assign s_d   = sum - p_q;
    assign r_out = r_d;
`endif

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= STARTER_STATE;
        else     state_q <= state_d;
    end

    // Next state and READY strobe.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        case (state_q)
            STARTER_STATE:
                if (bus.START)
                    state_d = (bus.SIZE_N_IN == '0) ? END_STATE : INPUT_STATE;
            INPUT_STATE:
                if (u_full_q && w_full_q && psi_full_q) state_d = MULTIPLY_STATE;
            MULTIPLY_STATE: state_d = ADD_STATE;
            ADD_STATE:      state_d = SCALE_STATE;
            SCALE_STATE:    state_d = OUTPUT_STATE;
            OUTPUT_STATE: begin
                if (last_elem) begin
                    state_d = END_STATE;
                    ready_d = 1'b1;
                end else begin
                    state_d = INPUT_STATE;
                end
            end
            END_STATE: begin
                state_d = STARTER_STATE;
                // An empty pass enters END straight from idle, so its READY
                // is issued on leaving END to land two cycles after START.
                ready_d = (size_q == '0);
            end
            default: state_d = STARTER_STATE;
        endcase
    end

    // Operand capture, element sequencing and the arithmetic pipeline.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            index_q    <= '0;
            size_q     <= DATA_SIZE'(ZERO);
            u_q        <= DATA_SIZE'(ZERO);
            w_q        <= DATA_SIZE'(ZERO);
            psi_q      <= DATA_SIZE'(ZERO);
            u_full_q   <= EMPTY;
            w_full_q   <= EMPTY;
            psi_full_q <= EMPTY;
            p_q        <= '0;
            s_q        <= '0;
            u_out_q    <= DATA_SIZE'(ZERO);
            u_out_en_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            // Result is registered leaving SCALE so it is valid during OUTPUT.
            u_out_en_q <= (state_q == SCALE_STATE);
            case (state_q)
                STARTER_STATE:
                    if (bus.START) begin
                        size_q  <= bus.SIZE_N_IN;
                        index_q <= '0;
                    end
                INPUT_STATE: begin
                    if (bus.U_IN_ENABLE) begin
                        u_q      <= bus.U_IN;
                        u_full_q <= FULL;
                    end
                    if (bus.W_IN_ENABLE) begin
                        w_q      <= bus.W_IN;
                        w_full_q <= FULL;
                    end
                    if (bus.PSI_IN_ENABLE) begin
                        psi_q      <= bus.PSI_IN;
                        psi_full_q <= FULL;
                    end
                end
                MULTIPLY_STATE: p_q     <= p_d;
                ADD_STATE:      s_q     <= s_d;
                SCALE_STATE:    u_out_q <= r_out;
                OUTPUT_STATE: begin
                    u_full_q   <= EMPTY;
                    w_full_q   <= EMPTY;
                    psi_full_q <= EMPTY;
                    if (!last_elem) index_q <= index_q + CONTROL_SIZE'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.READY        = ready_q;
    assign bus.U_OUT_ENABLE = u_out_en_q;
    assign bus.U_OUT        = u_out_q;
endmodule

// File: tb/tb_accelerator_usage_vector.sv
// Self-checking bench for accelerator_usage_vector (DATA_SIZE=32, FRACTION=16):
// directed cases plus random passes checked against an arithmetic model.
module tb_accelerator_usage_vector;
    localparam int DW = 32;
    localparam int F  = 16;

    typedef struct {
        int            e;
        logic [DW-1:0] v;
    } ev_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  out_q[$];
    ev_t  exp_q[$];
    int   rdy_q[$];
    int   exp_rdy[$];

    accelerator_usage_vector_if #(.DATA_SIZE(DW)) bus();

    accelerator_usage_vector #(
        .DATA_SIZE(DW), .CONTROL_SIZE(32), .FRACTION(F)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Record every output pulse with the number of rising edges seen so far.
    always @(negedge CLK) begin
        ev_t ev;
        if (bus.U_OUT_ENABLE) begin
            ev.e = edge_cnt;
            ev.v = bus.U_OUT;
            out_q.push_back(ev);
        end
        if (bus.READY) rdy_q.push_back(edge_cnt);
    end

    function automatic logic [DW-1:0] model(input logic [DW-1:0] u, w, psi);
        logic [127:0] p, s, r;
        p = (128'(u) * 128'(w)) >> F;
`ifdef ACCELERATOR_USAGE_VECTOR_SATURATE_EN
        if (128'(u) + 128'(w) < p) s = 128'd0;
        else                       s = 128'(u) + 128'(w) - p;
        r = (s * 128'(psi)) >> F;
        if (r > (128'd1 << F)) r = 128'd1 << F;
`else
        s = (128'(u) + 128'(w) - p) & ((128'd1 << (DW + 1)) - 128'd1);
        r = (s * 128'(psi)) >> F;
`endif
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd_val();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return $urandom_range(0, 32'h20000);
    endfunction

    task automatic chk(input string tag, input int idx, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s[%0d] got=%0h expected=%0h", tag, idx, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.START         = 1'b0;
        bus.U_IN_ENABLE   = 1'b0;
        bus.W_IN_ENABLE   = 1'b0;
        bus.PSI_IN_ENABLE = 1'b0;
        bus.SIZE_N_IN     = '0;
        bus.U_IN          = '0;
        bus.W_IN          = '0;
        bus.PSI_IN        = '0;
    endtask

    // START is sampled at edge s+1; SIZE_N_IN is scrambled afterwards.
    task automatic start_pass(input int n, output int s);
        @(negedge CLK);
        bus.START     = 1'b1;
        bus.SIZE_N_IN = n;
        s             = edge_cnt;
        @(negedge CLK);
        bus.START     = 1'b0;
        bus.SIZE_N_IN = $urandom;
    endtask

    // Present one element; each operand's enable fires after its own delay.
    task automatic drive_elem(input logic [DW-1:0] u, w, psi, input int du, dw, dp,
                              input logic [DW-1:0] expv, output int last);
        int  m;
        int  e0;
        ev_t ev;
        m  = du;
        if (dw > m) m = dw;
        if (dp > m) m = dp;
        e0 = 0;
        for (int t = 0; t <= m; t++) begin
            @(negedge CLK);
            if (t == 0) e0 = edge_cnt;
            bus.U_IN_ENABLE   = (t == du);
            bus.U_IN          = (t == du) ? u : $urandom;
            bus.W_IN_ENABLE   = (t == dw);
            bus.W_IN          = (t == dw) ? w : $urandom;
            bus.PSI_IN_ENABLE = (t == dp);
            bus.PSI_IN        = (t == dp) ? psi : $urandom;
        end
        @(negedge CLK);
        bus.U_IN_ENABLE   = 1'b0;
        bus.W_IN_ENABLE   = 1'b0;
        bus.PSI_IN_ENABLE = 1'b0;
        last = e0 + m + 1;
        ev.e = last + 4;
        ev.v = expv;
        exp_q.push_back(ev);
        while (edge_cnt < last + 5) @(negedge CLK);
    endtask

    task automatic check_pass(input string tag);
        int n;
        repeat (3) @(negedge CLK);
        #1;
        chk({tag, "_pulses"}, 0, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_edge"}, i, out_q[i].e, exp_q[i].e);
            chk({tag, "_val"}, i, out_q[i].v, exp_q[i].v);
        end
        chk({tag, "_readys"}, 0, rdy_q.size(), exp_rdy.size());
        n = (rdy_q.size() < exp_rdy.size()) ? rdy_q.size() : exp_rdy.size();
        for (int i = 0; i < n; i++) chk({tag, "_ready_edge"}, i, rdy_q[i], exp_rdy[i]);
        out_q.delete();
        exp_q.delete();
        rdy_q.delete();
        exp_rdy.delete();
    endtask

    initial begin
        int s;
        int last;
        int e;
        logic [DW-1:0] u, w, psi;

        idle_inputs();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_u_out", 0, bus.U_OUT, 0);
        chk("rst_u_out_en", 0, bus.U_OUT_ENABLE, 0);
        chk("rst_ready", 0, bus.READY, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Single element, all enables together.
        start_pass(1, s);
        drive_elem(32'h8000, 32'h8000, 32'h10000, 0, 0, 0, 32'hC000, last);
        exp_rdy.push_back(last + 5);
        check_pass("single");

        // Three elements with staggered enables: psi, u two later, w five after u.
        start_pass(3, s);
        for (int j = 0; j < 3; j++)
            drive_elem(32'h10000, 32'h10000, 32'h8000, 2, 7, 0, 32'h8000, last);
        exp_rdy.push_back(last + 5);
        check_pass("stagger");

        // Empty vector.
        start_pass(0, s);
        exp_rdy.push_back(s + 2);
        check_pass("empty");

        // Result above ONE.
        start_pass(1, s);
`ifdef ACCELERATOR_USAGE_VECTOR_SATURATE_EN
        drive_elem(32'h10000, 32'h0, 32'h20000, 1, 0, 2, 32'h10000, last);
`else
        drive_elem(32'h10000, 32'h0, 32'h20000, 1, 0, 2, 32'h20000, last);
`endif
        exp_rdy.push_back(last + 5);
        check_pass("sat_hi");

        // u*w exceeds u+w: s goes negative.
        start_pass(1, s);
`ifdef ACCELERATOR_USAGE_VECTOR_SATURATE_EN
        drive_elem(32'h0100_0000, 32'h0100_0000, 32'h10000, 0, 1, 0, 32'h0, last);
`else
        drive_elem(32'h0100_0000, 32'h0100_0000, 32'h10000, 0, 1, 0, 32'h0200_0000, last);
`endif
        exp_rdy.push_back(last + 5);
        check_pass("neg_s");

        // Reset while element 1 of 4 is in SCALE.
        start_pass(4, s);
        drive_elem(32'h8000, 32'h8000, 32'h10000, 0, 0, 0, 32'hC000, last);
        check_pass("abort_e0");
        @(negedge CLK);
        bus.U_IN_ENABLE = 1'b1; bus.U_IN = 32'h1234;
        bus.W_IN_ENABLE = 1'b1; bus.W_IN = 32'h5678;
        bus.PSI_IN_ENABLE = 1'b1; bus.PSI_IN = 32'h10000;
        e = edge_cnt + 1;
        @(negedge CLK);
        idle_inputs();
        while (edge_cnt < e + 3) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("abort_u_out", 0, bus.U_OUT, 0);
        chk("abort_u_out_en", 0, bus.U_OUT_ENABLE, 0);
        chk("abort_ready", 0, bus.READY, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (12) @(negedge CLK);
        check_pass("abort_quiet");
        start_pass(1, s);
        drive_elem(32'h0, 32'h4000, 32'h10000, 0, 0, 0, 32'h4000, last);
        exp_rdy.push_back(last + 5);
        check_pass("after_abort");

        // Second START while busy and a duplicated U_IN_ENABLE.
        start_pass(1, s);
        @(negedge CLK);
        bus.U_IN_ENABLE = 1'b1; bus.U_IN = 32'h1000;
        @(negedge CLK);
        bus.U_IN_ENABLE = 1'b0;
        bus.START = 1'b1; bus.SIZE_N_IN = 5;
        @(negedge CLK);
        bus.START = 1'b0;
        bus.U_IN_ENABLE = 1'b1; bus.U_IN = 32'h2000;
        @(negedge CLK);
        bus.U_IN_ENABLE = 1'b0;
        @(negedge CLK);
        bus.W_IN_ENABLE = 1'b1; bus.W_IN = 32'h0;
        bus.PSI_IN_ENABLE = 1'b1; bus.PSI_IN = 32'h10000;
        e = edge_cnt + 1;
        @(negedge CLK);
        idle_inputs();
        begin
            ev_t ev;
            ev.e = e + 4;
            ev.v = 32'h2000;
            exp_q.push_back(ev);
        end
        exp_rdy.push_back(e + 5);
        while (edge_cnt < e + 5) @(negedge CLK);
        check_pass("dup");

        // Random passes against the arithmetic model.
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 4);
            start_pass(n, s);
            for (int j = 0; j < n; j++) begin
                u   = rnd_val();
                w   = rnd_val();
                psi = rnd_val();
                drive_elem(u, w, psi, $urandom_range(0, 4), $urandom_range(0, 4),
                           $urandom_range(0, 4), model(u, w, psi), last);
            end
            exp_rdy.push_back(last + 5);
            check_pass("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
